fifo_sync_flex: RTL and testbench

FIFO_SYNC_FLEX -- requirements
Module: fifo_sync_flex

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_ram.sv | 38 +++
 rtl/fifo_sync_flex.sv | 171 +++++++++++++++++
 tb/tb_fifo_sync_flex.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO family.
//   FIFO_MODE_STD  : registered read; rd_data/rd_valid appear the cycle
//                    after an accepted pop.
//   FIFO_MODE_FWFT : first-word-fall-through; the head word is always
//                    presented on rd_data while the FIFO is not empty.
//   is_pow2()      : elaboration-time helper for parameter checks.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// DATA_W x DEPTH storage array: synchronous write, asynchronous read.
// Ports:
//   clk      in   write clock (rising edge)
//   we_i     in   write enable
//   waddr_i  in   write address  [AW-1:0]
//   wdata_i  in   write data     [DATA_W-1:0]
//   raddr_i  in   read address   [AW-1:0]
//   rdata_o  out  read data      [DATA_W-1:0], combinational from raddr_i
// ---------------------------------------------------------------------------
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset on purpose; the FIFO pointers decide
    // which entries are meaningful, and a reset port here would turn the
    // array into flops instead of a RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_ram

// File: rtl/fifo_sync_flex.sv
// ---------------------------------------------------------------------------
// fifo_sync_flex
// Single-clock FIFO with selectable read style (standard or FWFT),
// programmable almost-full/almost-empty levels and sticky error flags.
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   clr           in   synchronous flush (pointers, error flags, rd_valid)
//   wr_en/wr_data in   push request and word
//   rd_en         in   pop request
//   rd_data       out  read word
//   rd_valid      out  rd_data qualifier
//   full, empty, almost_full, almost_empty  out  status flags
//   count         out  occupancy 0..DEPTH
//   overflow      out  sticky: write attempted while full
//   underflow     out  sticky: read attempted while empty
// ---------------------------------------------------------------------------
module fifo_sync_flex
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int MODE      = FIFO_MODE_FWFT,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] AF_LVL  = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_LVL  = (AW+1)'(AE_THRESH);

    // ---------------- parameter legality ----------------
    if (DATA_W < 1) begin : g_bad_data_w
        $error("fifo_sync_flex: DATA_W must be >= 1");
    end
    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_sync_flex: DEPTH must be a power of 2 and >= 2");
    end
    if (MODE != FIFO_MODE_STD && MODE != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("fifo_sync_flex: MODE must be FIFO_MODE_STD or FIFO_MODE_FWFT");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_sync_flex: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_flex: AE_THRESH must be in 0..DEPTH-1");
    end

    // ---------------- pointer / flag state ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the address bits match.
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    // Acceptance looks only at registered full/empty: no same-cycle bypass,
    // and clr overrides both requests.
    assign wr_acc = wr_en && !full  && !clr;
    assign rd_acc = rd_en && !empty && !clr;

    // NOTE: combinational next-state logic uses blocking assignments with
    // every output defaulted first (no latches); the registers below use
    // non-blocking assignments only.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc)         wptr_d      = wptr_q + PTR_ONE;
            if (rd_acc)         rptr_d      = rptr_q + PTR_ONE;
            if (wr_en && full)  overflow_d  = 1'b1;
            if (rd_en && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Status is purely a function of registered pointers, so an asynchronous
    // reset drives every flag to its idle value without a clock.
    assign empty        = (wptr_q == rptr_q);
    assign full         = (wptr_q[AW] != rptr_q[AW]) &&
                          (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // ---------------- storage ----------------
    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // ---------------- read port ----------------
    if (MODE == FIFO_MODE_STD) begin : g_std
        logic [DATA_W-1:0] rd_data_q, rd_data_d;
        logic              rd_valid_q, rd_valid_d;

        // rd_acc is already false during clr, which also drops rd_valid;
        // rd_data simply holds its last popped word.
        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = rd_acc;
            if (rd_acc) rd_data_d = ram_rdata;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft
        assign rd_data  = ram_rdata;
        assign rd_valid = !empty;
    end

endmodule : fifo_sync_flex

// File: tb/tb_fifo_sync_flex.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_flex
// Drives one standard-mode and one FWFT-mode instance (DEPTH=8, DATA_W=8)
// from the same stimulus. A directed table with hand-computed expectations,
// a few hand-written corner sequences and a random phase checked against a
// queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fifo_sync_flex;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] s_rd_data, f_rd_data;
    logic       s_rd_valid, f_rd_valid;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0] s_count, f_count;

    always #5 clk = ~clk;

    fifo_sync_flex #(.DATA_W(8), .DEPTH(8), .MODE(FIFO_MODE_STD)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_count), .overflow(s_ovf), .underflow(s_udf)
    );

    fifo_sync_flex #(.DATA_W(8), .DEPTH(8), .MODE(FIFO_MODE_FWFT)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    // ---------------- reference model ----------------
    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    bit         m_rv  = 1'b0;
    logic [7:0] m_rd0 = 8'h00;

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_rv  = 1'b0;
        m_rd0 = 8'h00;
    endtask

    // One rising edge of the abstract FIFO: decisions use the pre-edge size.
    task automatic model_edge();
        bit was_full, was_empty;
        if (!rst_n) begin
            model_reset();
            return;
        end
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        if (clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rv  = 1'b0;
        end else begin
            if (wr_en && was_full)  m_ovf = 1'b1;
            if (rd_en && was_empty) m_udf = 1'b1;
            m_rv = rd_en && !was_empty;
            if (rd_en && !was_empty) m_rd0 = q.pop_front();
            if (wr_en && !was_full)  q.push_back(wr_data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, " std count"}, 32'(s_count), n);
        check({tag, " fwft count"}, 32'(f_count), n);
        check({tag, " std empty"}, 32'(s_empty), 32'(n == 0));
        check({tag, " fwft empty"}, 32'(f_empty), 32'(n == 0));
        check({tag, " std full"}, 32'(s_full), 32'(n == 8));
        check({tag, " fwft full"}, 32'(f_full), 32'(n == 8));
        check({tag, " almost_full"}, 32'(s_af), 32'(n >= 6));
        check({tag, " almost_empty"}, 32'(f_ae), 32'(n <= 1));
        check({tag, " std overflow"}, 32'(s_ovf), 32'(m_ovf));
        check({tag, " fwft underflow"}, 32'(f_udf), 32'(m_udf));
        check({tag, " std rd_valid"}, 32'(s_rd_valid), 32'(m_rv));
        check({tag, " std rd_data"}, 32'(s_rd_data), 32'(m_rd0));
        check({tag, " fwft rd_valid"}, 32'(f_rd_valid), 32'(n != 0));
        if (n != 0) check({tag, " fwft rd_data"}, 32'(f_rd_data), 32'(q[0]));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       wr, rd, clr;
        logic [7:0] din;
        int         cnt;
        logic       full, emp, af, ae, ovf, udf;
        logic       rv0;
        logic [7:0] rd0;
        logic       rv1;
        logic [7:0] rd1;
    } vec_t;

    function automatic vec_t mk(input logic wr, rd, cl, input logic [7:0] din, input int cnt,
                                input logic full, emp, af, ae, ovf, udf,
                                input logic rv0, input logic [7:0] rd0,
                                input logic rv1, input logic [7:0] rd1);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = cl; v.din = din; v.cnt = cnt;
        v.full = full; v.emp = emp; v.af = af; v.ae = ae; v.ovf = ovf; v.udf = udf;
        v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        //              wr rd cl din    cnt full emp af ae ovf udf rv0 rd0    rv1 rd1
        tbl.push_back(mk(1, 0, 0, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h02, 2, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h03, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h04, 4, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h05, 5, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h06, 6, 0, 0, 1, 0, 0, 0, 0, 8'h00, 1, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h07, 7, 0, 0, 1, 0, 0, 0, 0, 8'h00, 1, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h08, 8, 1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h09, 8, 1, 0, 1, 0, 1, 0, 0, 8'h00, 1, 8'h01));
        tbl.push_back(mk(0, 1, 0, 8'h00, 7, 0, 0, 1, 0, 1, 0, 1, 8'h01, 1, 8'h02));
        tbl.push_back(mk(0, 1, 0, 8'h00, 6, 0, 0, 1, 0, 1, 0, 1, 8'h02, 1, 8'h03));
        tbl.push_back(mk(0, 1, 0, 8'h00, 5, 0, 0, 0, 0, 1, 0, 1, 8'h03, 1, 8'h04));
        tbl.push_back(mk(0, 1, 0, 8'h00, 4, 0, 0, 0, 0, 1, 0, 1, 8'h04, 1, 8'h05));
        tbl.push_back(mk(0, 1, 0, 8'h00, 3, 0, 0, 0, 0, 1, 0, 1, 8'h05, 1, 8'h06));
        tbl.push_back(mk(0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 1, 0, 1, 8'h06, 1, 8'h07));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 1, 8'h07, 1, 8'h08));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 1, 8'h08, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 0, 8'h08, 0, 8'h00));
        tbl.push_back(mk(1, 1, 0, 8'hA5, 1, 0, 0, 0, 1, 1, 1, 0, 8'h08, 1, 8'hA5));
        tbl.push_back(mk(1, 1, 1, 8'h5A, 0, 0, 1, 0, 1, 0, 0, 0, 8'h08, 0, 8'h00));

        // ---- reset state ----
        model_reset();
        #1;
        check_all("reset");
        check("reset std rd_data", 32'(s_rd_data), 32'h0);
        #1 rst_n = 1'b1;

        // ---- directed table ----
        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("row%0d", i);
            wr_en = tbl[i].wr; rd_en = tbl[i].rd; clr = tbl[i].clr; wr_data = tbl[i].din;
            step();
            check({t, " std count"}, 32'(s_count), tbl[i].cnt);
            check({t, " fwft count"}, 32'(f_count), tbl[i].cnt);
            check({t, " full"}, 32'(s_full), 32'(tbl[i].full));
            check({t, " empty"}, 32'(f_empty), 32'(tbl[i].emp));
            check({t, " almost_full"}, 32'(f_af), 32'(tbl[i].af));
            check({t, " almost_empty"}, 32'(s_ae), 32'(tbl[i].ae));
            check({t, " overflow"}, 32'(s_ovf), 32'(tbl[i].ovf));
            check({t, " underflow"}, 32'(f_udf), 32'(tbl[i].udf));
            check({t, " std rd_valid"}, 32'(s_rd_valid), 32'(tbl[i].rv0));
            check({t, " std rd_data"}, 32'(s_rd_data), 32'(tbl[i].rd0));
            check({t, " fwft rd_valid"}, 32'(f_rd_valid), 32'(tbl[i].rv1));
            if (tbl[i].rv1) check({t, " fwft rd_data"}, 32'(f_rd_data), 32'(tbl[i].rd1));
        end
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;

        // ---- FWFT presentation of a single word, then pop ----
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check("fwft a5 rd_data", 32'(f_rd_data), 32'hA5);
        check("fwft a5 rd_valid", 32'(f_rd_valid), 32'h1);
        check("std a5 no early valid", 32'(s_rd_valid), 32'h0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("fwft a5 popped empty", 32'(f_empty), 32'h1);
        check("std a5 rd_valid", 32'(s_rd_valid), 32'h1);
        check("std a5 rd_data", 32'(s_rd_data), 32'hA5);
        step();
        check("std a5 valid pulse ends", 32'(s_rd_valid), 32'h0);
        check_all("after a5");

        // ---- steady state at count 4 across pointer wrap ----
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            step();
            check_all($sformatf("fill4 %0d", i));
        end
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'($urandom);
            step();
            check_all($sformatf("steady %0d", i));
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // ---- random traffic, write-biased then read-biased ----
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = (i < 300) ? 70 : 30;
            wr_en   = ($urandom_range(0, 99) < wp);
            rd_en   = ($urandom_range(0, 99) < (100 - wp));
            clr     = ($urandom_range(0, 99) < 2);
            wr_data = 8'($urandom);
            step();
            check_all($sformatf("rand %0d", i));
        end
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;

        // ---- asynchronous reset mid-burst at count 5 ----
        clr = 1'b1;
        step();
        clr = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
            step();
        end
        check_all("pre-reset");
        check("pre-reset count", 32'(s_count), 32'd5);
        #1 rst_n = 1'b0;
        #1;
        check("async rst count", 32'(s_count), 32'd0);
        check("async rst fwft count", 32'(f_count), 32'd0);
        check("async rst empty", 32'(s_empty), 32'h1);
        check("async rst full", 32'(f_full), 32'h0);
        check("async rst almost_empty", 32'(s_ae), 32'h1);
        check("async rst almost_full", 32'(f_af), 32'h0);
        check("async rst underflow", 32'(s_udf), 32'h0);
        check("async rst overflow", 32'(f_ovf), 32'h0);
        check("async rst std rd_valid", 32'(s_rd_valid), 32'h0);
        check("async rst std rd_data", 32'(s_rd_data), 32'h0);
        check("async rst fwft rd_valid", 32'(f_rd_valid), 32'h0);
        model_reset();
        step();
        check_all("held in reset");
        rst_n = 1'b1;
        wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = (i < 3); rd_en = (i >= 2); wr_data = 8'(8'h70 + i);
            step();
            check_all($sformatf("post-reset %0d", i));
        end
        wr_en = 1'b0; rd_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_sync_flex
